// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, error codes and parser state encoding
package uart_pkg;
  localparam logic [7:0] SYNC0 = 8'h55;
  localparam logic [7:0] SYNC1 = 8'hAA;
  localparam logic [2:0] ERR_CHK = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
  localparam logic [2:0] ERR_TMO = 3'd3;
  localparam logic [2:0] ERR_OVR = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if: held-frame read port between parser and command layer
interface uart_frame_parser_if #(
  parameter int AW = 4
);
  logic          frame_valid;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_ack;
  modport master (
    output frame_valid, frame_cmd, frame_len, rd_data,
    input  rd_addr, frame_ack
  );
  modport slave (
    input  frame_valid, frame_cmd, frame_len, rd_data,
    output rd_addr, frame_ack
  );
endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload register file, one write port and a registered read port
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem [MAX_LEN];
  logic [7:0] rd_sel;
  // store one payload byte per cycle
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    else
      for (int i = 0; i < MAX_LEN; i++)
        if (we_i && waddr_i == AW'(i)) mem[i] <= wdata_i;
  // read mux; addresses beyond the buffer return zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < MAX_LEN; i++)
      rd_sel = (raddr_i == AW'(i)) ? mem[i] : rd_sel;
  end
  // one-cycle read latency
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rdata_o <= '0;
    else rdata_o <= rd_sel;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: delineates 55 AA CMD LEN payload CHK frames from a UART byte stream
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int AW          = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  uart_frame_parser_if.master frm,
  output logic                err_o,
  output logic [2:0]          err_code_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t        state, state_d;
  logic [7:0]    sum, sum_d, idx, idx_d, cmd_q, cmd_d, len_q, len_d;
  logic [TW-1:0] cnt, cnt_d;
  logic          we, err_d;
  logic [2:0]    code_d;
  logic [7:0]    rd_data;
  logic          counting;
  assign frm.frame_valid = (state == ST_HOLD);
  assign frm.frame_cmd   = cmd_q;
  assign frm.frame_len   = len_q;
  assign frm.rd_data     = rd_data;
  assign counting = (state == ST_SYNC) || (state == ST_CMD) || (state == ST_LEN) ||
                    (state == ST_PAYLOAD) || (state == ST_CHK);
  uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (we),
    .waddr_i (AW'(idx)),
    .wdata_i (rx_data_i),
    .raddr_i (frm.rd_addr),
    .rdata_o (rd_data)
  );
  // parser registers: state, running checksum, payload index, inter-byte timer, frame header, error report
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      sum        <= '0;
      idx        <= '0;
      cnt        <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      state      <= state_d;
      sum        <= sum_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      err_o      <= err_d;
      err_code_o <= code_d;
    end
  // next-state: byte-driven frame walk, hold/ack handshake, overrun and inter-byte timeout
  always_comb begin
    state_d = state;
    sum_d   = sum;
    idx_d   = idx;
    cnt_d   = cnt;
    cmd_d   = cmd_q;
    len_d   = len_q;
    we      = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code_o;
    if (!en_i) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (rx_valid_i) begin
      cnt_d = '0;
      case (state)
        ST_IDLE: state_d = (rx_data_i == SYNC0) ? ST_SYNC : ST_IDLE;
        ST_SYNC: state_d = (rx_data_i == SYNC1) ? ST_CMD : (rx_data_i == SYNC0) ? ST_SYNC : ST_IDLE;
        ST_CMD: begin
          cmd_d   = rx_data_i;
          sum_d   = rx_data_i;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_data_i > 8'(MAX_LEN)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            len_d   = rx_data_i;
            sum_d   = sum + rx_data_i;
            idx_d   = '0;
            state_d = (rx_data_i == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          we      = 1'b1;
          sum_d   = sum + rx_data_i;
          idx_d   = idx + 8'd1;
          state_d = (idx + 8'd1 == len_q) ? ST_CHK : ST_PAYLOAD;
        end
        ST_CHK: begin
          state_d = (rx_data_i == sum) ? ST_HOLD : ST_IDLE;
          err_d   = (rx_data_i != sum);
          code_d  = (rx_data_i != sum) ? ERR_CHK : err_code_o;
        end
        ST_HOLD: begin
          err_d   = 1'b1;
          code_d  = ERR_OVR;
          state_d = frm.frame_ack ? ST_IDLE : ST_HOLD;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state == ST_HOLD) begin
      state_d = frm.frame_ack ? ST_IDLE : ST_HOLD;
    end else if (counting) begin
      if (cnt == TW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
        code_d  = ERR_TMO;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of zuart_controller's receive port and consumes its byte stream (oRxData / oRxDataValid).
- Delineates framed command packets: SYNC0=0x55, SYNC1=0xAA, CMD, LEN, LEN payload bytes, then CHK.
- Verifies length and checksum, and buffers the payload.
- Presents each good frame to the command layer through a random-access read port with a valid/ack handshake.

Parameters:
- MAX_LEN, 16, maximum payload bytes accepted; legal range 1..255.
- TIMEOUT_CYC, 50000, clk_i cycles allowed between bytes inside a frame before abort.
- AW, 4, payload read-address width; must satisfy 2**AW >= MAX_LEN.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  parser enable; low forces IDLE and ignores bytes
- rx_data_i  in  8  received byte (from oRxData)
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid (from oRxDataValid)
- frame_valid_o  out  1  good frame held in buffer
- frame_cmd_o  out  8  CMD of held frame
- frame_len_o  out  8  LEN of held frame
- rd_addr_i  in  AW  payload read address
- rd_data_o  out  8  payload byte at rd_addr_i, registered, 1-cycle latency
- frame_ack_i  in  1  consumer releases held frame
- err_o  out  1  one-cycle error pulse
- err_code_o  out  3  code of last error, held: 1=checksum, 2=length, 3=timeout, 4=overrun

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States and transitions (each advance consumes a byte only when rx_valid_i=1):
  - IDLE: byte 0x55 -> SYNC; any other byte is discarded.
  - SYNC: 0xAA -> CMD; 0x55 stays in SYNC; other -> IDLE, no error.
  - CMD: store byte, sum = byte -> LEN.
  - LEN: if byte > MAX_LEN -> IDLE, err 2. Otherwise store it and add to sum; if byte==0 -> CHK, else idx=0 -> PAYLOAD.
  - PAYLOAD: buf[idx]=byte, sum += byte, idx++. When idx reaches LEN -> CHK.
  - CHK: if byte == sum[7:0] -> HOLD and raise frame_valid_o in the next cycle; otherwise -> IDLE, err 1.
  - HOLD: frame_valid_o=1; cmd/len/buffer are frozen. frame_ack_i=1 -> IDLE; frame_valid_o drops the cycle after ack.
- Checksum: 8-bit sum modulo 256 of CMD, LEN and all payload bytes; sync bytes excluded.
- Timeout:
  - The counter is cleared on every rx_valid_i and counts only in SYNC, CMD, LEN, PAYLOAD and CHK.
  - When it reaches TIMEOUT_CYC-1 without a byte -> IDLE, err 3.
  - The counter is idle in IDLE and HOLD.
- Overrun: rx_valid_i in HOLD drops the byte and pulses err 4; the held frame is preserved.
- Simultaneous frame_ack_i and rx_valid_i in HOLD: ack wins and the byte is dropped with err 4. This is a deliberate simplification.
- en_i=0: state -> IDLE next cycle, frame_valid_o cleared, no error pulse; err_code_o retained.
- err_o is high exactly one cycle per event; err_code_o updates in that same cycle.
- rd_data_o reads buf[rd_addr_i]. Addresses >= frame_len_o return stale contents (undefined, not X-checked).
- rst_n_i low mid-frame: immediate return to reset values; the partial frame is discarded.
- Throughput: accepts one byte per cycle if strobes are back-to-back.

Decomposition:
- Shared package uart_pkg:
  - SYNC0/SYNC1 constants.
  - ERR_CHK/ERR_LEN/ERR_TMO/ERR_OVR codes.
  - State enum encodings.
- Natural sub-module uart_frame_buf: MAX_LEN x 8 register file with one write port and a registered read port.
- FSM, checksum, timeout counter and handshake stay in the top module.

Test Plan:
- Bytes 55 AA 01 03 10 20 30 64 -> frame_valid_o=1, cmd=0x01, len=3, rd_addr 0/1/2 gives 10/20/30 one cycle later; ack -> frame_valid_o=0.
- Same frame with CHK=0x65 -> err_o pulse, err_code_o=1, frame_valid_o stays 0; a following good frame is accepted.
- 55 AA 02 11 (LEN=17 > MAX_LEN) -> err_code_o=2, IDLE; 55 AA 02 00 02 -> valid frame, len=0.
- 55 55 AA 07 01 5A 62 -> SYNC re-sync works; valid frame, cmd=0x07, payload 5A.
- 55 AA 01 then silence for TIMEOUT_CYC cycles (set TIMEOUT_CYC=20 in the bench) -> err_code_o=3 after 20 cycles; state returns to IDLE.
- Byte during HOLD -> err_code_o=4, held payload unchanged; assert rst_n_i mid-payload -> all outputs 0, next frame parses cleanly.
